// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word-in / bit-out handshake bundle for the PISO serializer
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_ready;
  logic                  dout;
  logic                  dout_valid;
  logic                  dout_last;

  modport master (
    output din_valid,
    output din,
    input  din_ready,
    input  dout,
    input  dout_valid,
    input  dout_last
  );

  modport slave (
    input  din_valid,
    input  din,
    output din_ready,
    output dout,
    output dout_valid,
    output dout_last
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer, one bit per cycle with valid/last framing
module piso_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  piso_serializer_if.slave  bus
);
  localparam int             CW      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  PENULT  = CW'(DATA_WIDTH - 2);
  localparam int             OUT_IDX = MSB_FIRST ? DATA_WIDTH - 1 : 0;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  dout_valid, dout_valid_n;
  logic                  dout_last, dout_last_n;
  logic                  at_last;
  logic                  ready;
  logic                  accept;

  assign at_last = (state == SHIFT) && (cnt == LAST);
  assign ready   = (state == IDLE) || at_last;
  assign accept  = bus.din_valid && ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      dout_valid <= dout_valid_n;
      dout_last  <= dout_last_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (at_last && !accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The output bit is the output-end flop of sreg, so clearing sreg at end of word zeroes dout.
  always_comb begin
    sreg_n       = sreg;
    cnt_n        = cnt;
    dout_valid_n = dout_valid;
    dout_last_n  = dout_last;
    if (accept) begin
      sreg_n       = bus.din;
      cnt_n        = '0;
      dout_valid_n = 1'b1;
      dout_last_n  = 1'b0;
    end else if (state == SHIFT && !at_last) begin
      cnt_n        = cnt + CW'(1);
      sreg_n       = MSB_FIRST ? {sreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, sreg[DATA_WIDTH-1:1]};
      dout_valid_n = 1'b1;
      dout_last_n  = (cnt == PENULT);
    end else begin
      sreg_n       = '0;
      dout_valid_n = 1'b0;
      dout_last_n  = 1'b0;
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout       = sreg[OUT_IDX];
  assign bus.dout_valid = dout_valid;
  assign bus.dout_last  = dout_last;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] sipo = '0;

  always #5 clk = ~clk;

  piso_serializer_if #(.DATA_WIDTH(16)) bus_m ();
  piso_serializer_if #(.DATA_WIDTH(16)) bus_l ();

  piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .resetn(resetn), .bus(bus_m)
  );
  piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .resetn(resetn), .bus(bus_l)
  );

  // Behavioural left-shifting SIPO fed by the MSB-first instance.
  always @(posedge clk) begin
    if (bus_m.dout_valid) sipo <= {sipo[14:0], bus_m.dout};
  end

  task automatic test_reset();
    bus_m.din_valid = 1'b0; bus_m.din = '0;
    bus_l.din_valid = 1'b0; bus_l.din = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_m.dout, bus_m.dout_valid, bus_m.dout_last, bus_m.din_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_hold: got %b required 0001", {bus_m.dout, bus_m.dout_valid, bus_m.dout_last, bus_m.din_ready});
    end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_m.dout_valid, bus_m.din_ready, bus_l.dout_valid} !== 3'b010) begin
        failures++;
        $display("FAIL idle_after_reset cyc %0d: got %b required 010", i, {bus_m.dout_valid, bus_m.din_ready, bus_l.dout_valid});
      end
    end
    bus_m.din = 16'hFFFF; bus_m.din_valid = 1'b1;
    @(negedge clk);
    bus_m.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_m.dout, bus_m.dout_valid, bus_m.din_ready} !== 3'b110) begin
      failures++;
      $display("FAIL pre_reset_shift: got %b required 110", {bus_m.dout, bus_m.dout_valid, bus_m.din_ready});
    end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({bus_m.dout, bus_m.dout_valid, bus_m.dout_last} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: got %b required 000", {bus_m.dout, bus_m.dout_valid, bus_m.dout_last});
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_m.dout_valid, bus_m.din_ready} !== 2'b01) begin
        failures++;
        $display("FAIL no_resume cyc %0d: got %b required 01", i, {bus_m.dout_valid, bus_m.din_ready});
      end
    end
  endtask

  task automatic test_msb_single(input logic [15:0] word, input bit pulse_mid);
    logic [15:0] w;
    w = word;
    bus_m.din = w; bus_m.din_valid = 1'b1;
    @(negedge clk);
    bus_m.din_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({bus_m.dout, bus_m.dout_valid, bus_m.dout_last} !== {w[15-k], 1'b1, (k == 15)}) begin
        failures++;
        $display("FAIL msb_bit %0d of %h: got %b required %b", k, w,
                 {bus_m.dout, bus_m.dout_valid, bus_m.dout_last}, {w[15-k], 1'b1, (k == 15)});
      end
      if (pulse_mid && k == 5) begin
        checks++;
        if (bus_m.din_ready !== 1'b0) begin
          failures++;
          $display("FAIL held_ready: got %b required 0", bus_m.din_ready);
        end
        bus_m.din = 16'h1234; bus_m.din_valid = 1'b1;
      end else begin
        bus_m.din_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if ({bus_m.dout_valid, bus_m.dout_last, bus_m.din_ready} !== 3'b001) begin
      failures++;
      $display("FAIL msb_end: got %b required 001", {bus_m.dout_valid, bus_m.dout_last, bus_m.din_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    logic edge_c;
    bus_m.din = 16'hFFFF; bus_m.din_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      if (c == 0) bus_m.din = 16'h0001;
      if (c == 16) bus_m.din_valid = 1'b0;
      exp_bit = (c < 16) ? 1'b1 : (c == 31);
      edge_c  = (c == 15) || (c == 31);
      checks++;
      if ({bus_m.dout, bus_m.dout_valid, bus_m.dout_last, bus_m.din_ready} !== {exp_bit, 1'b1, edge_c, edge_c}) begin
        failures++;
        $display("FAIL b2b cyc %0d: got %b required %b", c,
                 {bus_m.dout, bus_m.dout_valid, bus_m.dout_last, bus_m.din_ready}, {exp_bit, 1'b1, edge_c, edge_c});
      end
      @(negedge clk);
    end
    checks++;
    if ({bus_m.dout_valid, bus_m.din_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_end: got %b required 01", {bus_m.dout_valid, bus_m.din_ready});
    end
  endtask

  task automatic test_lsb();
    logic [15:0] w;
    w = 16'h0003;
    bus_l.din = w; bus_l.din_valid = 1'b1;
    @(negedge clk);
    bus_l.din_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({bus_l.dout, bus_l.dout_valid, bus_l.dout_last} !== {(k < 2), 1'b1, (k == 15)}) begin
        failures++;
        $display("FAIL lsb_bit %0d: got %b required %b", k,
                 {bus_l.dout, bus_l.dout_valid, bus_l.dout_last}, {(k < 2), 1'b1, (k == 15)});
      end
      @(negedge clk);
    end
    checks++;
    if (bus_l.dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL lsb_end: got %b required 0", bus_l.dout_valid);
    end
  endtask

  task automatic test_loopback();
    logic [15:0] words [4];
    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'h0F0F; words[3] = 16'h8001;
    bus_m.din = words[0]; bus_m.din_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus_m.din = words[i+1];
      else       bus_m.din_valid = 1'b0;
      repeat (16) @(negedge clk);
      checks++;
      if (sipo !== words[i]) begin
        failures++;
        $display("FAIL loopback word %0d: got %h required %h", i, sipo, words[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_single(16'hA5C3, 1'b0);
    test_back_to_back();
    test_msb_single(16'hA5C3, 1'b1);
    test_lsb();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer that accepts a `DATA_WIDTH`-bit word over a valid/ready handshake and emits it one bit per cycle with valid and last-bit framing. It is the stage directly upstream of the team's SIPO shift register: its `dout` drives the SIPO's serial `din`, so a word serialized here reappears intact at the SIPO's parallel output. Back-to-back words stream with no idle cycle.

## Interface
- `DATA_WIDTH`, 16: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = transmit bit `DATA_WIDTH-1` first (matches the left-shifting SIPO); 0 = bit 0 first.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `din_valid`  in  1  upstream word valid.
- `din`  in  DATA_WIDTH  parallel word; sampled only on an accepted transfer.
- `din_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial bit, registered.
- `dout_valid`  out  1  `dout` carries a payload bit, registered.
- `dout_last`  out  1  `dout` is the final bit of the current word, registered.

## Operation
- State: shift register `sreg[DATA_WIDTH-1:0]`; bit counter `cnt` of width `$clog2(DATA_WIDTH)`; FSM with states IDLE and SHIFT.
- Reset (`resetn` low, asynchronous, takes effect immediately): FSM = IDLE, `sreg` = 0, `cnt` = 0, `dout` = 0, `dout_valid` = 0, `dout_last` = 0.
- `din_ready` is combinational from registered state: 1 in IDLE, or in SHIFT when `cnt == DATA_WIDTH-1`; 0 otherwise. Its value is 1 during and immediately after reset.
- Accept: on a rising edge with `din_valid && din_ready`:
  - load `sreg` ← `din`;
  - `cnt` ← 0;
  - FSM ← SHIFT;
  - `dout` ← first bit (`din[DATA_WIDTH-1]` if `MSB_FIRST`, else `din[0]`);
  - `dout_valid` ← 1.
- SHIFT, no accept, `cnt < DATA_WIDTH-1`:
  - `cnt` increments;
  - `sreg` shifts toward the output end;
  - `dout` ← next bit;
  - `dout_last` ← 1 when the new `cnt == DATA_WIDTH-1`.
- SHIFT, `cnt == DATA_WIDTH-1`, no accept: FSM ← IDLE; `dout`, `dout_valid` and `dout_last` ← 0.
- SHIFT, `cnt == DATA_WIDTH-1`, accept: the new word loads as in Accept, with no gap cycle; `dout_last` ← 0.
- IDLE with `din_valid` low: all outputs hold 0.
- `din` and `din_valid` are ignored while `din_ready` is 0. Upstream holds the word until accepted; no buffering beyond `sreg`.
- Reset asserted mid-word: the partial word is discarded, no resumption, and the outputs go to their reset values asynchronously.

## Timing
- Accept at edge E: the first bit is valid on `dout` after edge E. Bit k (transmit order) is on `dout` after edge E+k, for k = 0..DATA_WIDTH-1.
- `dout_last` is high exactly in the cycle after edge E+DATA_WIDTH-1.
- Throughput: 1 bit/cycle; a continuous stream accepts one word every `DATA_WIDTH` cycles.
- With `MSB_FIRST`=1 feeding the SIPO: the SIPO parallel output equals the accepted word after edge E+DATA_WIDTH.
- `dout_valid` stays high continuously across back-to-back words. `dout_last` pulses once per word.

## Test plan
- **Reset values:** assert `resetn` asynchronously mid-cycle with the FSM in SHIFT → `dout`/`dout_valid`/`dout_last` = 0 immediately; `din_ready` = 1 after release; no bits emitted with `din_valid` low.
- **Single word, MSB first:** `DATA_WIDTH`=16, `MSB_FIRST`=1, accept 0xA5C3 at edge E → `dout` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over edges E..E+15. `dout_last` only on the final bit. `dout_valid` falls after E+16.
- **Back-to-back words:** hold `din_valid` high with 0xFFFF then 0x0001 → 32 consecutive valid cycles, `dout_last` at cycles 15 and 31. `din_ready` high only in IDLE and on last-bit cycles. The second word starts with no gap.
- **Held word ignored:** change `din` to 0x1234 and pulse `din_valid` at cnt=5 → no accept; the current word's bits are unchanged.
- **LSB first:** `MSB_FIRST`=0, accept 0x0003 → `dout` = 1,1 followed by 14 zeros.
- **SIPO loopback:** chain into the SIPO (`DATA_WIDTH`=16) and send random words back-to-back → the SIPO output equals each word exactly `DATA_WIDTH` edges after its accept.
